// File: rtl/rectangle128_rkey_reader_if.sv
// rtl/rectangle128_rkey_reader_if.sv - key-write and round-key stream bundle
// Master is the key-schedule generator / consumer side; slave is the reader.
interface rectangle128_rkey_reader_if;
  logic        flush;
  logic        WE;
  logic [4:0]  WAddr;
  logic [63:0] KeyIn;
  logic        Start;
  logic        Decrypt;
  logic        RkReady;
  logic [63:0] RoundKey;
  logic        RkValid;
  logic [4:0]  RkIdx;
  logic        RkLast;
  logic        KeysReady;
  logic        Busy;

  modport master (
    output flush, WE, WAddr, KeyIn, Start, Decrypt, RkReady,
    input  RoundKey, RkValid, RkIdx, RkLast, KeysReady, Busy
  );

  modport slave (
    input  flush, WE, WAddr, KeyIn, Start, Decrypt, RkReady,
    output RoundKey, RkValid, RkIdx, RkLast, KeysReady, Busy
  );
endinterface

// File: rtl/rectangle128_rkey_reader.sv
// rtl/rectangle128_rkey_reader.sv - round-key store and ordered key streamer
// Keys are written by the schedule generator, then streamed forward or reversed.
module rectangle128_rkey_reader #(
  parameter int NUM_RK = 26
) (
  input logic                        Clk,
  input logic                        RstN,
  rectangle128_rkey_reader_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [5:0] NUM_RK_W = 6'(NUM_RK);
  localparam logic [4:0] LAST_IDX = 5'(NUM_RK - 1);

  logic [63:0]       keys_q [NUM_RK];
  logic [NUM_RK-1:0] valid_q, valid_d;
  logic [1:0]        state_q, state_d;
  logic              dir_q, dir_d;
  logic [4:0]        idx_q, idx_d;
  logic [63:0]       key_q, key_d;
  logic              rk_valid_q, rk_valid_d;
  logic              rk_last_q, rk_last_d;

  logic              wr_ok;
  logic              keys_ready;
  logic              load_en;
  logic [4:0]        load_idx;

  assign wr_ok      = bus.WE && ({1'b0, bus.WAddr} < NUM_RK_W);
  assign keys_ready = &valid_q;

  // Storage is deliberately not reset; nothing reads an entry before its valid flag is set.
  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      keys_q[bus.WAddr] <= bus.KeyIn;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (wr_ok) begin
      valid_d[bus.WAddr] = 1'b1;
    end
    if (!bus.flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    idx_d      = idx_q;
    key_d      = key_q;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;
    load_en    = 1'b0;
    load_idx   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          dir_d = bus.Decrypt;
          if (keys_ready && bus.flush) begin
            load_en  = 1'b1;
            load_idx = bus.Decrypt ? LAST_IDX : 5'd0;
            state_d  = ST_STREAM;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.flush) begin
          state_d = ST_IDLE;
        end else if (keys_ready) begin
          load_en  = 1'b1;
          load_idx = dir_q ? LAST_IDX : 5'd0;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!bus.flush) begin
          state_d    = ST_IDLE;
          rk_valid_d = 1'b0;
          rk_last_d  = 1'b0;
        end else if (bus.RkReady) begin
          if (rk_last_q) begin
            state_d    = ST_IDLE;
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
          end else begin
            load_en  = 1'b1;
            load_idx = dir_q ? (idx_q - 5'd1) : (idx_q + 5'd1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        rk_valid_d = 1'b0;
        rk_last_d  = 1'b0;
      end
    endcase

    // The presented key is a registered copy, so later writes to that index do not disturb it.
    if (load_en) begin
      idx_d      = load_idx;
      key_d      = keys_q[load_idx];
      rk_valid_d = 1'b1;
      rk_last_d  = dir_d ? (load_idx == 5'd0) : (load_idx == LAST_IDX);
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      valid_q    <= '0;
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      idx_q      <= 5'd0;
      key_q      <= 64'd0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      idx_q      <= idx_d;
      key_q      <= key_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
    end
  end

  assign bus.RoundKey  = key_q;
  assign bus.RkValid   = rk_valid_q;
  assign bus.RkIdx     = idx_q;
  assign bus.RkLast    = rk_last_q;
  assign bus.KeysReady = keys_ready;
  assign bus.Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rectangle128_rkey_reader.sv
// tb/tb_rectangle128_rkey_reader.sv - self-checking bench for the round-key reader
// Reference keeps the key table and valid flags as plain arrays; streams are index queues.
module tb_rectangle128_rkey_reader;

  logic Clk = 1'b0;
  logic RstN;
  always #5 Clk = ~Clk;

  rectangle128_rkey_reader_if bus();

  rectangle128_rkey_reader #(.NUM_RK(26)) dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] ref_keys [26];
  bit          ref_valid [26];

  function automatic bit all_valid();
    for (int i = 0; i < 26; i++) begin
      if (!ref_valid[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 26; i++) ref_valid[i] = 1'b0;
  endtask

  // One write cycle; returns on the next falling edge with the write committed.
  task automatic wr(input int idx, input logic [63:0] key);
    bus.WE    = 1'b1;
    bus.WAddr = 5'(idx);
    bus.KeyIn = key;
    @(negedge Clk);
    bus.WE = 1'b0;
    if (idx < 26) begin
      ref_keys[idx]  = key;
      ref_valid[idx] = 1'b1;
    end
    chk("keys_ready_after_write", 64'(bus.KeysReady), 64'(all_valid()));
  endtask

  task automatic wr_all_random();
    int perm [26];
    int j, t;
    for (int i = 0; i < 26; i++) perm[i] = i;
    for (int i = 25; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 26; i++) wr(perm[i], {$urandom(), $urandom()});
  endtask

  task automatic start_req(input bit dir);
    bus.Start   = 1'b1;
    bus.Decrypt = dir;
    bus.RkReady = 1'b0;
    @(negedge Clk);
    bus.Start   = 1'b0;
    bus.Decrypt = 1'($urandom_range(1, 0));
  endtask

  // mode 0: always ready, 1: ready toggles 0,1,..., 2: random ready
  task automatic follow(input bit dir, input int mode, input int abort_at, input int rst_at,
                        input bit glitch, input bit wr_cur);
    int          q[$];
    logic [63:0] exp_key;
    int          cyc;
    bit          rdy;
    bit          tog;
    bit          wrote;
    cyc = 0; tog = 1'b0; wrote = 1'b0;
    for (int i = 0; i < 26; i++) q.push_back(dir ? 25 - i : i);
    exp_key = ref_keys[q[0]];
    while (q.size() > 0 && cyc < 200) begin
      chk("rk_valid", 64'(bus.RkValid), 64'd1);
      chk("rk_idx", 64'(bus.RkIdx), 64'(q[0]));
      chk("round_key", bus.RoundKey, exp_key);
      chk("rk_last", 64'(bus.RkLast), 64'(q.size() == 1));
      chk("busy_stream", 64'(bus.Busy), 64'd1);
      if (q[0] == abort_at) begin
        bus.flush   = 1'b0;
        bus.RkReady = 1'($urandom_range(1, 0));
        @(negedge Clk);
        bus.flush   = 1'b1;
        bus.RkReady = 1'b0;
        clear_model();
        chk("abort_rk_valid", 64'(bus.RkValid), 64'd0);
        chk("abort_busy", 64'(bus.Busy), 64'd0);
        chk("abort_keys_ready", 64'(bus.KeysReady), 64'd0);
        @(negedge Clk);
        chk("abort_stays_idle", 64'(bus.RkValid), 64'd0);
        return;
      end
      if (q[0] == rst_at) begin
        bus.RkReady = 1'b1;
        #2 RstN = 1'b0;
        #1;
        chk("rst_round_key", bus.RoundKey, 64'd0);
        chk("rst_rk_valid", 64'(bus.RkValid), 64'd0);
        chk("rst_rk_idx", 64'(bus.RkIdx), 64'd0);
        chk("rst_rk_last", 64'(bus.RkLast), 64'd0);
        chk("rst_keys_ready", 64'(bus.KeysReady), 64'd0);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        bus.RkReady = 1'b0;
        @(negedge Clk);
        RstN = 1'b1;
        clear_model();
        @(negedge Clk);
        chk("post_rst_keys_ready", 64'(bus.KeysReady), 64'd0);
        chk("post_rst_rk_valid", 64'(bus.RkValid), 64'd0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      if (wr_cur && !rdy && !wrote) begin
        bus.WE        = 1'b1;
        bus.WAddr     = 5'(q[0]);
        bus.KeyIn     = {$urandom(), $urandom()};
        ref_keys[q[0]] = bus.KeyIn;
        wrote         = 1'b1;
      end
      bus.Start   = glitch && (cyc == 3);
      bus.Decrypt = bus.Start ? ~dir : 1'($urandom_range(1, 0));
      bus.RkReady = rdy;
      @(negedge Clk);
      bus.WE      = 1'b0;
      bus.Start   = 1'b0;
      bus.RkReady = 1'b0;
      cyc++;
      if (rdy) begin
        void'(q.pop_front());
        if (q.size() > 0) exp_key = ref_keys[q[0]];
      end
    end
    chk("stream_len", 64'(q.size()), 64'd0);
    chk("end_rk_valid", 64'(bus.RkValid), 64'd0);
    chk("end_busy", 64'(bus.Busy), 64'd0);
    @(negedge Clk);
    chk("restart_ignored_busy", 64'(bus.Busy), 64'd0);
  endtask

  initial begin
    RstN        = 1'b0;
    bus.flush   = 1'b1;
    bus.WE      = 1'b0;
    bus.WAddr   = 5'd0;
    bus.KeyIn   = 64'd0;
    bus.Start   = 1'b0;
    bus.Decrypt = 1'b0;
    bus.RkReady = 1'b0;
    clear_model();
    for (int i = 0; i < 26; i++) ref_keys[i] = 64'd0;

    @(negedge Clk);
    @(negedge Clk);
    chk("reset_round_key", bus.RoundKey, 64'd0);
    chk("reset_rk_valid", 64'(bus.RkValid), 64'd0);
    chk("reset_rk_idx", 64'(bus.RkIdx), 64'd0);
    chk("reset_rk_last", 64'(bus.RkLast), 64'd0);
    chk("reset_keys_ready", 64'(bus.KeysReady), 64'd0);
    chk("reset_busy", 64'(bus.Busy), 64'd0);
    RstN = 1'b1;
    @(negedge Clk);

    // Forward stream of the fixed key pattern, with a stray Start mid-stream
    for (int i = 0; i < 26; i++) wr(i, 64'h1111_0000_0000_0000 + 64'(i));
    start_req(1'b0);
    follow(1'b0, 0, -1, -1, 1'b1, 1'b0);

    // Out-of-range writes leave storage and flags untouched
    wr(27, 64'hDEAD_BEEF_DEAD_BEEF);
    wr(26, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("oob_keys_ready", 64'(bus.KeysReady), 64'd1);

    // Reverse stream with stalls; one write lands on the presented index
    start_req(1'b1);
    follow(1'b1, 1, -1, -1, 1'b1, 1'b1);

    start_req(1'b0);
    follow(1'b0, 2, -1, -1, 1'b0, 1'b0);

    // Start before the last key is written waits, then streams
    bus.flush = 1'b0;
    @(negedge Clk);
    bus.flush = 1'b1;
    clear_model();
    chk("flush_keys_ready", 64'(bus.KeysReady), 64'd0);
    for (int i = 0; i < 25; i++) wr(i, {$urandom(), $urandom()});
    start_req(1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("wait_busy", 64'(bus.Busy), 64'd1);
      chk("wait_rk_valid", 64'(bus.RkValid), 64'd0);
      bus.Start   = (c == 1);
      bus.Decrypt = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
    end
    wr(25, {$urandom(), $urandom()});
    chk("wait_still_no_valid", 64'(bus.RkValid), 64'd0);
    @(negedge Clk);
    follow(1'b0, 2, 10, -1, 1'b0, 1'b0);

    // After the flush abort, Start parks in WAIT until flushed out
    start_req(1'b0);
    chk("flushed_start_busy", 64'(bus.Busy), 64'd1);
    chk("flushed_start_rk_valid", 64'(bus.RkValid), 64'd0);
    bus.flush = 1'b0;
    @(negedge Clk);
    bus.flush = 1'b1;
    chk("wait_flush_busy", 64'(bus.Busy), 64'd0);

    // Asynchronous reset mid reverse stream, then full rewrite
    wr_all_random();
    start_req(1'b1);
    follow(1'b1, 2, -1, 5, 1'b0, 1'b0);
    wr_all_random();
    start_req(1'b0);
    follow(1'b0, 2, -1, -1, 1'b1, 1'b1);
    start_req(1'b1);
    follow(1'b1, 2, -1, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
